// File: rtl/simd4_wr_packer_if.sv
// Bundle-side write lanes, flush control and the packed-word memory write port of simd4_wr_packer.
interface simd4_wr_packer_if #(
  parameter int AW = 10
);
  logic [AW-1:0] in_waddr0, in_waddr1, in_waddr2, in_waddr3;
  logic [7:0]    in_wdata0, in_wdata1, in_wdata2, in_wdata3;
  logic          in_we0, in_we1, in_we2, in_we3;
  logic          i_flush;
  logic          i_mem_ready;
  logic [AW-3:0] o_mem_waddr;
  logic [31:0]   o_mem_wdata;
  logic [3:0]    o_mem_be;
  logic          o_mem_we;
  logic          o_flush_done;
  logic          o_overflow;
  logic          o_err;
  logic [31:0]   o_word_count;

  modport master (
    output in_waddr0, in_waddr1, in_waddr2, in_waddr3,
    output in_wdata0, in_wdata1, in_wdata2, in_wdata3,
    output in_we0, in_we1, in_we2, in_we3,
    output i_flush, i_mem_ready,
    input  o_mem_waddr, o_mem_wdata, o_mem_be, o_mem_we,
    input  o_flush_done, o_overflow, o_err, o_word_count
  );

  modport slave (
    input  in_waddr0, in_waddr1, in_waddr2, in_waddr3,
    input  in_wdata0, in_wdata1, in_wdata2, in_wdata3,
    input  in_we0, in_we1, in_we2, in_we3,
    input  i_flush, i_mem_ready,
    output o_mem_waddr, o_mem_wdata, o_mem_be, o_mem_we,
    output o_flush_done, o_overflow, o_err, o_word_count
  );
endinterface

// File: rtl/simd4_wr_packer.sv
// Merges SIMD4 byte-lane write bundles into 32-bit words queued in a FIFO for a wide memory.
// A word reaches the FIFO head one cycle after its push; the head holds while i_mem_ready is low.
module simd4_wr_packer #(
  parameter int AW         = 10,
  parameter int FIFO_DEPTH = 8
) (
  input logic              clk,
  input logic              rst_n,
  simd4_wr_packer_if.slave bus
);
  localparam int WW = AW - 2;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [WW-1:0] waddr;
    logic [31:0]   data;
    logic [3:0]    be;
  } word_t;

  typedef enum logic [1:0] {S_RUN, S_FLUSH, S_DRAIN} state_t;

  state_t        state_q, state_d;
  word_t         ow_q, ow_d;
  logic          ow_vld_q, ow_vld_d;
  logic          pend_q, pend_d;
  logic          ovf_q, ovf_d;
  logic          err_q, err_d;
  logic          done_q, done_d;
  logic [31:0]   wcnt_q, wcnt_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  word_t         fifo_q [FIFO_DEPTH];

  logic [AW-1:0] lane_addr [4];
  logic [7:0]    lane_dat [4];
  logic [3:0]    lane_we;

  assign lane_addr[0] = bus.in_waddr0;
  assign lane_addr[1] = bus.in_waddr1;
  assign lane_addr[2] = bus.in_waddr2;
  assign lane_addr[3] = bus.in_waddr3;
  assign lane_dat[0]  = bus.in_wdata0;
  assign lane_dat[1]  = bus.in_wdata1;
  assign lane_dat[2]  = bus.in_wdata2;
  assign lane_dat[3]  = bus.in_wdata3;
  assign lane_we      = {bus.in_we3, bus.in_we2, bus.in_we1, bus.in_we0};

  logic          bundle, legal, spill, hit, push_ow, push_w0;
  logic [63:0]   win_dat;
  logic [7:0]    win_be;
  logic [WW-1:0] w0;
  logic [31:0]   mrg_dat;
  logic [3:0]    mrg_be;
  word_t         w0_word;

  // Bundle bytes are laid into a two-word window starting at the lane-0 byte offset.
  always_comb begin
    logic [2:0] pos;
    pos     = '0;
    win_dat = '0;
    win_be  = '0;
    legal   = (lane_we == 4'b0001) || (lane_we == 4'b0011) ||
              (lane_we == 4'b0111) || (lane_we == 4'b1111);
    for (int k = 0; k < 4; k++) begin
      if (lane_we[k]) begin
        if (lane_addr[k] != lane_addr[0] + AW'(k)) legal = 1'b0;
        pos = {1'b0, lane_addr[0][1:0]} + 3'(k);
        win_dat[{pos, 3'b000} +: 8] = lane_dat[k];
        win_be[pos] = 1'b1;
      end
    end
  end

  assign bundle  = |lane_we;
  assign w0      = lane_addr[0][AW-1:2];
  assign spill   = |win_be[7:4];
  assign hit     = ow_vld_q && (ow_q.waddr == w0);
  assign push_ow = ow_vld_q && !hit;

  always_comb begin
    mrg_dat = '0;
    mrg_be  = (hit ? ow_q.be : 4'h0) | win_be[3:0];
    for (int b = 0; b < 4; b++) begin
      mrg_dat[8*b +: 8] = win_be[b] ? win_dat[8*b +: 8] : (hit ? ow_q.data[8*b +: 8] : 8'h00);
    end
  end

  assign push_w0 = spill || (mrg_be == 4'hF);
  assign w0_word = '{waddr: w0, data: mrg_dat, be: mrg_be};

  logic       free2, free1, pop, mem_we;
  logic [1:0] npush;
  word_t      ent0, ent1, head;

  // Space is judged on the pre-pop count so a dual push can never overrun the FIFO.
  assign free2  = cnt_q <= CW'(FIFO_DEPTH - 2);
  assign free1  = cnt_q < CW'(FIFO_DEPTH);
  assign mem_we = cnt_q != '0;
  assign pop    = mem_we && bus.i_mem_ready;

  always_comb begin
    state_d  = state_q;
    ow_d     = ow_q;
    ow_vld_d = ow_vld_q;
    pend_d   = pend_q;
    ovf_d    = ovf_q;
    err_d    = err_q;
    done_d   = 1'b0;
    npush    = 2'd0;
    ent0     = push_ow ? ow_q : w0_word;
    ent1     = w0_word;
    case (state_q)
      S_RUN: begin
        if (bundle) begin
          if (!legal) begin
            err_d = 1'b1;
          end else if (!free2) begin
            ovf_d = 1'b1;
          end else begin
            npush = {1'b0, push_ow} + {1'b0, push_w0};
            if (spill) begin
              ow_vld_d = 1'b1;
              ow_d     = '{waddr: w0 + WW'(1), data: win_dat[63:32], be: win_be[7:4]};
            end else if (push_w0) begin
              ow_vld_d = 1'b0;
            end else begin
              ow_vld_d = 1'b1;
              ow_d     = w0_word;
            end
          end
        end
        if (pend_q) begin
          state_d = S_FLUSH;
          pend_d  = 1'b0;
        end else if (bus.i_flush) begin
          if (bundle) pend_d = 1'b1;
          else        state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (bundle) err_d = 1'b1;
        if (!ow_vld_q) begin
          state_d = S_DRAIN;
        end else if (free1) begin
          npush    = 2'd1;
          ent0     = ow_q;
          ow_vld_d = 1'b0;
          state_d  = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (bundle) err_d = 1'b1;
        if (cnt_q == '0) begin
          done_d  = 1'b1;
          state_d = S_RUN;
        end
      end
      default: state_d = S_RUN;
    endcase
  end

  assign cnt_d    = cnt_q + CW'(npush) - CW'(pop);
  assign wr_ptr_d = wr_ptr_q + PW'(npush);
  assign rd_ptr_d = rd_ptr_q + PW'(pop);
  assign wcnt_d   = wcnt_q + 32'(pop);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_RUN;
      ow_q     <= '0;
      ow_vld_q <= 1'b0;
      pend_q   <= 1'b0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
      wcnt_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      ow_q     <= ow_d;
      ow_vld_q <= ow_vld_d;
      pend_q   <= pend_d;
      ovf_q    <= ovf_d;
      err_q    <= err_d;
      done_q   <= done_d;
      wcnt_q   <= wcnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: an empty count gates every output field.
  always_ff @(posedge clk) begin
    if (npush != 2'd0) fifo_q[wr_ptr_q] <= ent0;
    if (npush == 2'd2) fifo_q[wr_ptr_q + PW'(1)] <= ent1;
  end

  assign head             = fifo_q[rd_ptr_q];
  assign bus.o_mem_we     = mem_we;
  assign bus.o_mem_waddr  = mem_we ? head.waddr : '0;
  assign bus.o_mem_wdata  = mem_we ? head.data : '0;
  assign bus.o_mem_be     = mem_we ? head.be : '0;
  assign bus.o_flush_done = done_q;
  assign bus.o_overflow   = ovf_q;
  assign bus.o_err        = err_q;
  assign bus.o_word_count = wcnt_q;
endmodule

// File: doc/simd4_wr_packer.md
SIMD4_WR_PACKER -- requirements
Module: simd4_wr_packer

Interface
REQ-001 Parameter AW, default 10, is the byte address width of the output image buffer; the word address is AW-2 bits.
REQ-002 Parameter FIFO_DEPTH, default 8, is the number of packed-word FIFO entries; it SHALL be a power of two and at least 4.
REQ-003 clk  in  1  single clock; all logic SHALL be on its rising edge.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 in_waddrK  in  AW  byte address of lane K (K=0..3), from the bilinear SIMD4 write ports.
REQ-006 in_wdataK  in  8  byte data of lane K.
REQ-007 in_weK  in  1  lane K write strobe; any strobe high marks a bundle cycle.
REQ-008 i_flush  in  1  single-cycle pulse to emit the open word and drain the FIFO.
REQ-009 i_mem_ready  in  1  wide output memory accepts the presented word this cycle.
REQ-010 o_mem_waddr  out  AW-2  word address, equal to byte address >> 2.
REQ-011 o_mem_wdata  out  32  packed data, little-endian: byte b of the word occupies bits [8b+7:8b].
REQ-012 o_mem_be  out  4  byte enables.
REQ-013 o_mem_we  out  1  valid; high exactly while the FIFO is non-empty.
REQ-014 o_flush_done  out  1  one-cycle pulse when the flush completes.
REQ-015 o_overflow  out  1  sticky flag: a bundle was dropped because of insufficient FIFO space.
REQ-016 o_err  out  1  sticky flag: a malformed bundle was dropped, or a bundle arrived while not in S_RUN.
REQ-017 o_word_count  out  32  number of words accepted by memory (o_mem_we && i_mem_ready).

Function
REQ-018 A bundle is legal only when:
  - the enabled lanes form a prefix (we pattern 0001, 0011, 0111 or 1111);
  - lane k carries address in_waddr0+k.
  Any other pattern SHALL set o_err and drop the bundle with no state change.
REQ-019 The block SHALL hold an open-word register OW {valid, waddr, data, be}, and bundle bytes SHALL merge into OW at lane offset addr[1:0].
REQ-020 With W0 = in_waddr0>>2, a legal bundle SHALL push entries as follows:
  - OW first, if OW is valid and OW.waddr != W0;
  - then the W0 portion, if the bundle spills into W0+1, or if the merged be reaches 4'hF.
REQ-021 After a spill, OW SHALL hold only the W0+1 bytes; after a full W0 push with no spill, OW.valid SHALL be 0.
REQ-022 At most 2 pushes SHALL occur per cycle.
REQ-023 A bundle SHALL be accepted only if the FIFO has at least 2 free entries, counted before this cycle's pop; otherwise the block SHALL drop it, set o_overflow and leave OW unchanged.
REQ-024 A push decided in cycle t SHALL be visible at the FIFO head no earlier than cycle t+1.
REQ-025 Output ordering SHALL be strictly push order; on a dual push, OW SHALL be ordered before the W0 portion.
REQ-026 The head SHALL pop on o_mem_we && i_mem_ready, and the outputs SHALL hold stable while i_mem_ready=0.
REQ-027 A push and a pop in the same cycle SHALL both take effect.
REQ-028 The FSM SHALL have the states S_RUN, S_FLUSH and S_DRAIN.
REQ-029 In S_RUN, i_flush with no bundle SHALL go to S_FLUSH.
REQ-030 In S_RUN, i_flush coincident with a bundle SHALL:
  - process the bundle first;
  - latch the flush as pending;
  - enter S_FLUSH in the next cycle.
REQ-031 In S_FLUSH:
  - if OW is valid, the block SHALL push OW as-is and clear OW.valid;
  - it SHALL wait for 1 free entry before pushing;
  - it SHALL then go to S_DRAIN.
REQ-032 In S_DRAIN the block SHALL wait until the FIFO is empty, then pulse o_flush_done for one cycle and return to S_RUN.
REQ-033 Bundles arriving in S_FLUSH or S_DRAIN SHALL be dropped and SHALL set o_err.
REQ-034 The FIFO pointers and count SHALL wrap modulo FIFO_DEPTH, and the count SHALL never exceed FIFO_DEPTH.
REQ-035 o_word_count SHALL wrap at 2^32.

Reset
REQ-036 While rst_n=0 at a clock edge, the block SHALL:
  - clear all outputs to 0;
  - set state to S_RUN;
  - clear OW.valid, the FIFO (empty), the flush-pending latch, the sticky flags and the counter.
REQ-037 A reset asserted mid-drain SHALL discard the FIFO contents and OW, with no o_flush_done pulse.

Verification
REQ-038 Aligned bundle: addresses 0..3, data 11,22,33,44, ready=1 -> next cycle o_mem_we=1, waddr=0, wdata=0x44332211, be=F; o_word_count=1.
REQ-039 Unaligned, three steps:
  - bundle at addresses 2..5, data A0..A3 -> word 0 be=1100 wdata[31:16]=A1A0; OW=word 1 be=0011;
  - bundle at addresses 6..9, data B0..B3 -> word 1 data {B1,B0,A3,A2} be=F; OW=word 2 be=0011;
  - i_flush -> word 2 be=0011; o_flush_done pulses once after the FIFO empties.
REQ-040 Partial bundle: we=0011 at addresses 14,15, OW empty -> no write; a following i_flush -> waddr=3, be=1100.
REQ-041 Backpressure: i_mem_ready=0, 7 aligned bundles to words 0..6, then an 8th bundle -> 8th dropped, o_overflow=1; ready=1 -> words 0..6 emitted in order; o_word_count=7.
REQ-042 Malformed bundle: we=1010, or lane1 address not lane0+1 -> o_err=1, no push, OW unchanged; the same fault in S_DRAIN -> o_err=1.
REQ-043 Reset in S_DRAIN with 3 entries queued -> o_mem_we=0 and o_flush_done=0 in the following cycle; flags and counter are 0.
